// File: rtl/pipe_buf_pkg.sv
// rtl/pipe_buf_pkg.sv - shared types and constants for the elastic pipeline boundary register
//
// Contents:
//   pb_state_t : buffer state; the encoding equals the number of entries held
//   NOP_INSTR  : RISC-V NOP (addi x0,x0,0), a reset value for instruction-bearing payloads
package pipe_buf_pkg;

    typedef enum logic [1:0] {
        PB_EMPTY = 2'd0,
        PB_ONE   = 2'd1,
        PB_FULL  = 2'd2
    } pb_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/pipe_buf_perf_cnt.sv
// rtl/pipe_buf_perf_cnt.sv - saturating event counter
//
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset, clears the count
//   inc   : count one event this cycle
//   cnt   : current count, sticks at all-ones
module pipe_buf_perf_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/pipe_buf_stage.sv
// rtl/pipe_buf_stage.sv - elastic pipeline boundary register with 2-entry skid buffer
//
// Optional feature macro: PIPE_BUF_PERF_CNT_EN (stall/flush performance counters).
//
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset
//   flush     : synchronous squash of all buffered entries (highest priority)
//   in_valid  : upstream payload valid
//   in_ready  : stage can accept; decoded from the state register only
//   in_data   : upstream payload
//   out_valid : downstream payload valid
//   out_ready : downstream accepts; low = stall
//   out_data  : payload to downstream (main register)
//   occupancy : entries held, 0..2
//   stall_cnt : cycles with in_valid & !in_ready (macro only, else 0)
//   flush_cnt : cycles with flush while non-empty (macro only, else 0)
module pipe_buf_stage
    import pipe_buf_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    pb_state_t         state, state_nxt;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_fire, out_fire;

    // Both handshake outputs come straight from the state flops, so neither
    // depends combinationally on the neighbouring stage.
    assign in_ready  = (state != PB_FULL);
    assign out_valid = (state != PB_EMPTY);
    assign out_data  = main_q;
    assign occupancy = state;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= PB_EMPTY;
            main_q <= RESET_VAL;
            skid_q <= RESET_VAL;
        end else begin
            state  <= state_nxt;
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    always_comb begin
        state_nxt = state;
        main_d    = main_q;
        skid_d    = skid_q;
        if (flush) begin
            // Squash drops a same-cycle in_fire; a same-cycle out_fire has
            // already been taken by downstream and needs no action here.
            state_nxt = PB_EMPTY;
            main_d    = RESET_VAL;
            skid_d    = RESET_VAL;
        end else begin
            case (state)
                PB_EMPTY: begin
                    if (in_fire) begin
                        main_d    = in_data;
                        state_nxt = PB_ONE;
                    end
                end
                PB_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        // Downstream stalled: park the new word behind main.
                        skid_d    = in_data;
                        state_nxt = PB_FULL;
                    end else if (out_fire) begin
                        state_nxt = PB_EMPTY;
                    end
                end
                PB_FULL: begin
                    if (out_fire) begin
                        main_d    = skid_q;
                        state_nxt = PB_ONE;
                    end
                end
                default: begin
                    state_nxt = PB_EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_BUF_PERF_CNT_EN
    pipe_buf_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (in_valid & ~in_ready),
        .cnt   (stall_cnt)
    );

    pipe_buf_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush & (state != PB_EMPTY)),
        .cnt   (flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_buf_stage.sv
// tb/tb_pipe_buf_stage.sv - directed self-checking bench for pipe_buf_stage
module tb_pipe_buf_stage;

    localparam logic [31:0] RST_VAL = 32'h00000013;
`ifdef PIPE_BUF_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [1:0]  occupancy;
    logic [3:0]  stall_cnt;
    logic [3:0]  flush_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    pipe_buf_stage #(
        .DATA_W    (32),
        .RESET_VAL (RST_VAL),
        .CNT_W     (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_valid = 1'b1; in_data = 32'hDEAD; out_ready = 1'b0;
        repeat (3) tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else pass_cnt++;
        total_cnt++; if (occupancy !== 2'd0) $display("FAIL rst_occupancy: got %0d want 0", occupancy); else pass_cnt++;
        total_cnt++; if (out_data !== RST_VAL) $display("FAIL rst_out_data: got %h want %h", out_data, RST_VAL); else pass_cnt++;
        total_cnt++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) $display("FAIL rst_counters: got %h/%h want 0/0", stall_cnt, flush_cnt); else pass_cnt++;
        reset = 1'b1;
        tick();
        total_cnt++; if (out_data !== 32'hDEAD || out_valid !== 1'b1) $display("FAIL rst_first_load: got %h/%b want dead/1", out_data, out_valid); else pass_cnt++;
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        total_cnt++; if (occupancy !== 2'd0) $display("FAIL rst_drain: got %0d want 0", occupancy); else pass_cnt++;
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = i;
            tick();
            total_cnt++;
            if (out_data !== i || out_valid !== 1'b1 || in_ready !== 1'b1 || occupancy !== 2'd1)
                $display("FAIL stream_%0d: got data=%h v=%b rdy=%b occ=%0d want data=%h v=1 rdy=1 occ=1",
                         i, out_data, out_valid, in_ready, occupancy, i);
            else pass_cnt++;
        end
        in_valid = 1'b0;
        tick();
        total_cnt++; if (occupancy !== 2'd0 || out_valid !== 1'b0) $display("FAIL stream_drain: got occ=%0d v=%b want 0/0", occupancy, out_valid); else pass_cnt++;
    endtask

    task automatic test_stall_skid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA;
        tick();
        total_cnt++; if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_data !== 32'hA) $display("FAIL skid_a: got occ=%0d rdy=%b data=%h want 1/1/a", occupancy, in_ready, out_data); else pass_cnt++;
        in_data = 32'hB;
        tick();
        total_cnt++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hA) $display("FAIL skid_b: got occ=%0d rdy=%b data=%h want 2/0/a", occupancy, in_ready, out_data); else pass_cnt++;
        in_data = 32'hC;
        tick();
        tick();
        total_cnt++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hA) $display("FAIL skid_hold: got occ=%0d rdy=%b data=%h want 2/0/a", occupancy, in_ready, out_data); else pass_cnt++;
        out_ready = 1'b1;
        tick();
        total_cnt++; if (out_data !== 32'hB || occupancy !== 2'd1) $display("FAIL skid_out_b: got data=%h occ=%0d want b/1", out_data, occupancy); else pass_cnt++;
        tick();
        total_cnt++; if (out_data !== 32'hC || occupancy !== 2'd1) $display("FAIL skid_out_c: got data=%h occ=%0d want c/1", out_data, occupancy); else pass_cnt++;
        in_valid = 1'b0;
        tick();
        total_cnt++; if (occupancy !== 2'd0) $display("FAIL skid_drain: got %0d want 0", occupancy); else pass_cnt++;
        // Stalled edges: two while held at FULL, one on the edge that drains main.
        total_cnt++; if (stall_cnt !== (PERF_ON ? 4'd3 : 4'd0)) $display("FAIL skid_stall_cnt: got %0d want %0d", stall_cnt, PERF_ON ? 3 : 0); else pass_cnt++;
    endtask

    task automatic test_flush_full();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h11;
        tick();
        in_data = 32'h22;
        tick();
        total_cnt++; if (occupancy !== 2'd2) $display("FAIL flush_fill: got %0d want 2", occupancy); else pass_cnt++;
        flush = 1'b1; in_data = 32'h55;
        tick();
        total_cnt++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL flush_empty: got occ=%0d v=%b rdy=%b want 0/0/1", occupancy, out_valid, in_ready); else pass_cnt++;
        total_cnt++; if (out_data !== RST_VAL) $display("FAIL flush_data: got %h want %h", out_data, RST_VAL); else pass_cnt++;
        total_cnt++; if (flush_cnt !== (PERF_ON ? 4'd1 : 4'd0)) $display("FAIL flush_cnt_1: got %0d want %0d", flush_cnt, PERF_ON ? 1 : 0); else pass_cnt++;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_no_55: got v=%b data=%h want v=0", out_valid, out_data); else pass_cnt++;
        in_valid = 1'b1; in_data = 32'h66;
        tick();
        total_cnt++; if (out_data !== 32'h66 || out_valid !== 1'b1) $display("FAIL flush_after: got %h/%b want 66/1", out_data, out_valid); else pass_cnt++;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h100;
        tick();
        for (int i = 1; i <= 4; i++) begin
            in_data = 32'h100 + i;
            tick();
            total_cnt++;
            if (occupancy !== 2'd1 || out_data !== 32'h100 + i)
                $display("FAIL b2b_%0d: got occ=%0d data=%h want 1/%h", i, occupancy, out_data, 32'h100 + i);
            else pass_cnt++;
        end
        // Stall count only grew in the FULL episodes earlier: 3 in skid test plus the flush edge.
        total_cnt++; if (stall_cnt !== (PERF_ON ? 4'd4 : 4'd0)) $display("FAIL b2b_stall_cnt: got %0d want %0d", stall_cnt, PERF_ON ? 4 : 0); else pass_cnt++;
        flush = 1'b1; in_data = 32'h1FF;
        tick();
        total_cnt++; if (occupancy !== 2'd0 || out_valid !== 1'b0) $display("FAIL b2b_flush: got occ=%0d v=%b want 0/0", occupancy, out_valid); else pass_cnt++;
        total_cnt++; if (flush_cnt !== (PERF_ON ? 4'd2 : 4'd0)) $display("FAIL flush_cnt_2: got %0d want %0d", flush_cnt, PERF_ON ? 2 : 0); else pass_cnt++;
        flush = 1'b0; in_valid = 1'b0;
        tick();
    endtask

    task automatic test_saturation();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h7;
        tick();
        in_data = 32'h8;
        tick();
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 10) begin
                total_cnt++; if (stall_cnt !== (PERF_ON ? 4'hE : 4'd0)) $display("FAIL sat_pre: got %h want %h", stall_cnt, PERF_ON ? 4'hE : 4'h0); else pass_cnt++;
            end
        end
        total_cnt++; if (stall_cnt !== (PERF_ON ? 4'hF : 4'd0)) $display("FAIL sat_stall_cnt: got %h want %h", stall_cnt, PERF_ON ? 4'hF : 4'h0); else pass_cnt++;
        total_cnt++; if (occupancy !== 2'd2 || out_data !== 32'h7) $display("FAIL sat_hold: got occ=%0d data=%h want 2/7", occupancy, out_data); else pass_cnt++;
        flush = 1'b1; in_valid = 1'b0;
        tick();
        flush = 1'b0;
        total_cnt++; if (flush_cnt !== (PERF_ON ? 4'd3 : 4'd0) || occupancy !== 2'd0) $display("FAIL sat_flush: got cnt=%0d occ=%0d want %0d/0", flush_cnt, occupancy, PERF_ON ? 3 : 0); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall_skid();
        test_flush_full();
        test_back_to_back();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pipe_buf_stage.md
Name: pipe_buf_stage

Overview:
Parametrised, elastic pipeline boundary register. It is the successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB structs.
- Carries any packed stage payload of DATA_W bits.
- Uses a valid/ready handshake with a 2-entry skid buffer, so upstream ready is a registered signal.
- Supports a synchronous flush for branch and JAL squashes.
- One instance sits between each pair of pipeline stages of the RISC-V core.

Parameters:
DATA_W, 32, payload width; instantiations pass $bits(<stage struct>).
RESET_VAL, '0, value loaded into both data registers on reset and flush; set to 32'h00000013 (NOP) for instruction-bearing payloads if desired.
CNT_W, 16, width of the performance counters; used only with the optional feature.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset).
flush  in  1  synchronous squash of all buffered entries.
in_valid  in  1  upstream payload valid.
in_ready  out  1  stage can accept; registered.
in_data  in  DATA_W  upstream payload.
out_valid  out  1  downstream payload valid.
out_ready  in  1  downstream accepts; low = stall.
out_data  out  DATA_W  payload to downstream.
occupancy  out  2  entries held: 0, 1 or 2.
stall_cnt  out  CNT_W  PIPE_BUF_PERF_CNT_EN only.
flush_cnt  out  CNT_W  PIPE_BUF_PERF_CNT_EN only.

Behaviour:
- Storage: main register (drives out_data/out_valid) and skid register.
- Fire definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- State encoding: EMPTY (occ 0), ONE (main valid), FULL (main + skid valid).
- Reset (reset=0, async):
  - state EMPTY.
  - out_valid=0; in_ready=1; occupancy=0.
  - main and skid data = RESET_VAL; counters = 0.
- Derived outputs:
  - in_ready = (state != FULL), taken from the register.
  - out_valid = (state != EMPTY).
  - out_data = main; occupancy = state encoding.
- Transitions when flush=0:
  - EMPTY, in_fire: main<=in_data, go to ONE.
  - ONE, in_fire & out_fire: main<=in_data, stay ONE. This is the full-throughput case.
  - ONE, in_fire only: skid<=in_data, go to FULL.
  - ONE, out_fire only: go to EMPTY.
  - FULL, out_fire: main<=skid, go to ONE.
  - FULL: in_valid is ignored, because in_ready=0.
  - Any other combination holds state.
- Latency and ordering:
  - Latency 1 cycle from in_fire to out_valid when EMPTY.
  - Throughput 1 per cycle in steady state.
  - Order is strictly FIFO.
- Data registers load only on the events above; otherwise they hold.
- Payload is don't-care while its valid bit is 0, but data must not change while out_valid=1 and out_ready=0 (stall stability).
- flush=1 (highest priority):
  - Next state EMPTY.
  - main and skid <= RESET_VAL.
  - A same-cycle in_fire is discarded.
  - A same-cycle out_fire still counts as consumed downstream.
- in_valid=1 with in_ready=0 is legal. Upstream must hold in_data stable until in_fire.
- reset asserted mid-transfer: entries are lost immediately; no output glitches beyond the asynchronous clear.

Optional Feature:
Macro PIPE_BUF_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on each cycle with in_valid & !in_ready.
  - flush_cnt increments on each cycle with flush=1 while occupancy!=0.
  - Both saturate at all-ones and clear on reset.
- Undefined: both ports are still present but tied to '0, and no counter flops are generated.

Decomposition:
- Package pipe_buf_pkg holds:
  - typedef enum logic [1:0] {PB_EMPTY=2'd0, PB_ONE=2'd1, PB_FULL=2'd2} pb_state_t;
  - localparam NOP_INSTR = 32'h00000013.
- The existing stage structs stay in Pipe_Buf_Reg_PKG and are used only via $bits at instantiation.
- One sub-module: pipe_buf_perf_cnt, a saturating CNT_W counter with inc, instanced twice under the macro.

Test Plan:
- Reset: hold reset=0 for 3 cycles with in_valid=1, in_data=32'hDEAD → out_valid=0, in_ready=1, occupancy=0, out_data=RESET_VAL. Release, then on the next edge main=32'hDEAD.
- Streaming: 8 words 0x1..0x8 with out_ready=1 → outputs 0x1..0x8 on consecutive cycles, 1 cycle behind input; in_ready stays 1; occupancy stays 1.
- Stall/skid: send 0xA, 0xB, 0xC back-to-back with out_ready=0 → occupancy 1 then 2; in_ready=0 after 0xB; 0xC is held upstream; out_data holds 0xA. Raise out_ready → 0xA, 0xB, 0xC in order.
- Flush while FULL: flush=1 with in_valid=1 and in_data=0x55 → next cycle occupancy=0, out_valid=0, 0x55 never appears; flush_cnt=1 (macro on).
- Simultaneous in_fire & out_fire in ONE: state stays ONE and out_data takes the new word each cycle; with the macro on, stall_cnt=0 throughout.
- Counter saturation: CNT_W=4, stall 20 cycles → stall_cnt=4'hF. With the macro undefined → stall_cnt=0.
